multicycle_control: RTL

- Sequenced successor to the combinational RV32I main decoder: a multi-cycle FSM that drives fetch, decode, execute, memory and writeback control for a shared-datapath RV32I core.
- Keeps the existing aluop/alusrc/regwrite/memtoreg/branch/jump encodings.
- Adds the following:
  - req/ack handshakes on instruction and data memory.
  - Byte-lane write enables.
  - A bus timeout watchdog.
  - A trap state.
- Sits between the memory interfaces and the datapath. Holds its own instruction register (IR).

---
 rtl/multicycle_control.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_control.sv
// Multi-cycle RV32I control FSM: sequences fetch/decode/execute/mem/writeback, with a bus watchdog and an absorbing trap state.
// Define ILLEGAL_TRAP_EN to trap on unknown opcodes (illegal=1); otherwise they retire as NOPs.
module multicycle_control #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        imem_ack,
  input  logic [31:0] idata,
  input  logic        dmem_ack,
  input  logic [1:0]  daddr_lo,
  output logic        imem_req,
  output logic        ir_write,
  output logic        pc_inc,
  output logic [1:0]  aluop,
  output logic [1:0]  alusrc,
  output logic        regwrite,
  output logic        memtoreg,
  output logic        branch,
  output logic        jump,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [3:0]  dwe,
  output logic        trap,
  output logic        bus_err,
  output logic        illegal,
  output logic [2:0]  state_o
);
  typedef enum logic [2:0] {
    BOOT      = 3'd0,
    FETCH     = 3'd1,
    DECODE    = 3'd2,
    EXECUTE   = 3'd3,
    MEM       = 3'd4,
    WRITEBACK = 3'd5,
    TRAP      = 3'd7
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam bit             WD_EN    = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT != 0) ? CNT_W'(TIMEOUT - 1) : '0;

  state_t           state, state_nx;
  logic [31:0]      ir;
  logic [CNT_W-1:0] cnt;
  logic             bus_err_q;
  logic             bus_req, bus_ack, wd_fire;

  logic [6:0] opc;
  logic       is_load, is_store, is_branch, is_jump, is_alu, is_wb, is_known;
  logic       unused_ir;

  assign opc       = ir[6:0];
  assign is_load   = (opc == OP_LOAD);
  assign is_store  = (opc == OP_STORE);
  assign is_branch = (opc == OP_BRANCH);
  assign is_jump   = (opc == OP_JAL) || (opc == OP_JALR);
  assign is_alu    = (opc == OP_R) || (opc == OP_I);
  assign is_wb     = is_alu || is_jump || (opc == OP_LUI) || (opc == OP_AUIPC);
  assign is_known  = is_wb || is_load || is_store || is_branch;
  assign unused_ir = ^{ir[31:14], ir[11:7]};

`ifdef ILLEGAL_TRAP_EN
  logic illegal_q, illegal_set;
  assign illegal = illegal_q;
`else
  assign illegal = 1'b0;
`endif

  assign state_o = state;
  assign bus_err = bus_err_q;

  always_comb begin
    state_nx = state;
    imem_req = 1'b0;
    ir_write = 1'b0;
    pc_inc   = 1'b0;
    aluop    = 2'b00;
    alusrc   = 2'b00;
    regwrite = 1'b0;
    memtoreg = 1'b0;
    branch   = 1'b0;
    jump     = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    dwe      = 4'b0000;
    trap     = 1'b0;
    bus_req  = 1'b0;
    bus_ack  = 1'b0;
    wd_fire  = 1'b0;
`ifdef ILLEGAL_TRAP_EN
    illegal_set = 1'b0;
`endif

    if (state inside {DECODE, EXECUTE, MEM, WRITEBACK}) begin
      aluop  = is_branch ? 2'b01 : (is_alu ? 2'b10 : 2'b00);
      alusrc = (opc == OP_AUIPC) ? 2'b11 :
               ((is_store || is_load || opc == OP_I || opc == OP_LUI) ? 2'b01 : 2'b00);
    end

    case (state)
      BOOT: state_nx = FETCH;
      FETCH: begin
        imem_req = 1'b1;
        bus_req  = 1'b1;
        bus_ack  = imem_ack;
        if (imem_ack) begin
          ir_write = 1'b1;
          pc_inc   = 1'b1;
          state_nx = DECODE;
        end
      end
      DECODE: begin
        if (is_known) begin
          state_nx = EXECUTE;
        end else begin
`ifdef ILLEGAL_TRAP_EN
          state_nx    = TRAP;
          illegal_set = 1'b1;
`else
          state_nx    = FETCH;
`endif
        end
      end
      EXECUTE: begin
        if (is_load || is_store) begin
          state_nx = MEM;
        end else if (is_branch) begin
          branch   = 1'b1;
          state_nx = FETCH;
        end else if (is_wb) begin
          state_nx = WRITEBACK;
        end else begin
          state_nx = FETCH;
        end
      end
      MEM: begin
        dmem_req = 1'b1;
        dmem_we  = is_store;
        bus_req  = 1'b1;
        bus_ack  = dmem_ack;
        if (is_store) begin
          case (ir[13:12])
            2'b00:   dwe = 4'b0001 << daddr_lo;
            2'b01:   dwe = 4'b0011 << {daddr_lo[1], 1'b0};
            2'b10:   dwe = 4'b1111;
            default: dwe = 4'b0000;
          endcase
        end
        if (dmem_ack) state_nx = is_load ? WRITEBACK : FETCH;
      end
      WRITEBACK: begin
        regwrite = 1'b1;
        memtoreg = is_load;
        jump     = is_jump;
        state_nx = FETCH;
      end
      TRAP:    trap = 1'b1;
      default: state_nx = BOOT;
    endcase

    // An ack in the expiry cycle takes priority over the watchdog.
    if (WD_EN && bus_req && !bus_ack && (cnt == CNT_LAST)) begin
      state_nx = TRAP;
      wd_fire  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= BOOT;
      ir        <= '0;
      cnt       <= '0;
      bus_err_q <= 1'b0;
    end else begin
      state <= state_nx;
      if (ir_write) ir <= idata;
      if ((state_nx != state) || !bus_req || bus_ack) cnt <= '0;
      else                                           cnt <= cnt + 1'b1;
      if (wd_fire) bus_err_q <= 1'b1;
    end
  end

`ifdef ILLEGAL_TRAP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           illegal_q <= 1'b0;
    else if (illegal_set) illegal_q <= 1'b1;
  end
`endif

endmodule
